// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and imem byte-write port used by imem_loader.
// The loader takes the slave side; the UART/imem side takes the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Framed program loader: LEN_LO, LEN_HI, payload, XOR checksum -> imem writes.
// Holds the CPU in reset while loading and reports sticky done/error flags.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int LEN_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        acc_q, acc_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  len_full;
  logic              xfer;

  assign bus.rx_ready = (state_q == S_LEN_LO) ||
                        (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   ||
                        (state_q == S_CHK);

  assign xfer = bus.rx_valid && bus.rx_ready;

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign cpu_hold    = hold_q;
  assign load_done   = done_q;
  assign load_err    = err_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    len_full  = {bus.rx_data, len_q[7:0]};
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          // Oversize images are refused before any write can wrap the address
          if (len_full > LEN_W'(DEPTH)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (len_full == '0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = bus.rx_data;
          cnt_d     = cnt_q + 1'b1;
          acc_d     = acc_q ^ bus.rx_data;
          if (cnt_q == len_q - 1'b1) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (bus.rx_data == acc_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: drivers queue expected writes,
// a negedge monitor pops and checks address, data and write cycle.
module tb_imem_loader;

  typedef logic [7:0] u8_t;
  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold;
  logic load_done;
  logic load_err;

  imem_loader_if bus ();

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         checks = 0;
  int         fails  = 0;
  logic [9:0] last_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0].c < cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      fails++;
      $display("FAIL missing_write actual=none required=addr %0h data %0h",
               mon_e.a, mon_e.d);
    end
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write actual=addr %0h data %0h required=none",
                 bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(mon_e.a));
        chk("wr_data", 32'(bus.wr_data), 32'(mon_e.d));
        chk("wr_cycle", cyc, mon_e.c);
        last_addr = bus.wr_addr;
      end
    end
  end

  task automatic send_byte(input u8_t b, input bit is_data,
                           input int addr, input bit gaps);
    bit ok = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.rx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL rx_ready_timeout actual=0 required=1 byte=%0h", b);
    end else if (is_data) begin
      exp_q.push_back('{a: 10'(addr), d: b, c: cyc + 1});
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_load(input u8_t d[$], input u8_t chkb, input bit gaps);
    logic [15:0] len = 16'(d.size());
    send_byte(len[7:0], 1'b0, 0, gaps);
    send_byte(len[15:8], 1'b0, 0, gaps);
    foreach (d[i]) send_byte(d[i], 1'b1, i, gaps);
    send_byte(chkb, 1'b0, 0, gaps);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string nm, input logic d, input logic e,
                           input logic h);
    chk({nm, "_done"}, 32'(load_done), 32'(d));
    chk({nm, "_err"}, 32'(load_err), 32'(e));
    chk({nm, "_hold"}, 32'(cpu_hold), 32'(h));
  endtask

  u8_t f1[$];
  u8_t fbad[$];
  u8_t fnone[$];
  u8_t fbig[$];
  u8_t xbig;

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    f1   = '{8'h13, 8'h00, 8'h00, 8'h00};
    fbad = '{8'hAA, 8'h55};
    xbig = '0;
    for (int i = 0; i < 1024; i++) begin
      fbig.push_back(u8_t'(i * 37 + 5));
      xbig = xbig ^ u8_t'(i * 37 + 5);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    chk("rst_rx_ready", 32'(bus.rx_ready), 0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    realign();
    rst = 1'b0;
    realign();

    // nominal load, payload 13 00 00 00, checksum 13
    pulse_start();
    @(negedge clk);
    chk_flags("armed", 1'b0, 1'b0, 1'b1);
    chk("armed_rx_ready", 32'(bus.rx_ready), 1);
    realign();
    send_load(f1, 8'h13, 1'b0);
    @(negedge clk);
    chk_flags("nominal", 1'b1, 1'b0, 1'b0);
    chk("done_rx_ready", 32'(bus.rx_ready), 0);
    realign();

    // same frame with random gaps
    pulse_start();
    send_load(f1, 8'h13, 1'b1);
    @(negedge clk);
    chk_flags("gaps", 1'b1, 1'b0, 1'b0);
    realign();

    // bad checksum: AA^55 = FF, sent 00
    pulse_start();
    send_load(fbad, 8'h00, 1'b0);
    @(negedge clk);
    chk_flags("badchk", 1'b0, 1'b1, 1'b1);
    realign();
    pulse_start();
    @(negedge clk);
    chk_flags("rearm", 1'b0, 1'b0, 1'b1);
    realign();

    // zero length, checksum 00
    send_load(fnone, 8'h00, 1'b0);
    @(negedge clk);
    chk_flags("len0", 1'b1, 1'b0, 1'b0);
    realign();

    // length 1025 rejected after LEN_HI
    pulse_start();
    send_byte(8'h01, 1'b0, 0, 1'b0);
    send_byte(8'h04, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk_flags("len1025", 1'b0, 1'b1, 1'b1);
    chk("len1025_rx_ready", 32'(bus.rx_ready), 0);
    realign();

    // full 1024-byte image
    pulse_start();
    send_load(fbig, xbig, 1'b0);
    @(negedge clk);
    chk_flags("len1024", 1'b1, 1'b0, 1'b0);
    chk("len1024_last_addr", 32'(last_addr), 32'h3FF);
    realign();

    // reset after two of four data bytes
    pulse_start();
    send_byte(8'h04, 1'b0, 0, 1'b0);
    send_byte(8'h00, 1'b0, 0, 1'b0);
    send_byte(8'h11, 1'b1, 0, 1'b0);
    send_byte(8'h22, 1'b1, 1, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h33;
    rst          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_wr_en", 32'(bus.wr_en), 0);
    chk("midrst_rx_ready", 32'(bus.rx_ready), 0);
    chk_flags("midrst", 1'b0, 1'b0, 1'b0);
    realign();
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    realign();
    pulse_start();
    send_load(f1, 8'h13, 1'b0);
    @(negedge clk);
    chk_flags("postrst", 1'b1, 1'b0, 1'b0);
    realign();

    // start during S_DATA is ignored
    pulse_start();
    send_byte(8'h04, 1'b0, 0, 1'b0);
    send_byte(8'h00, 1'b0, 0, 1'b0);
    send_byte(8'h13, 1'b1, 0, 1'b0);
    pulse_start();
    @(negedge clk);
    chk_flags("ignstart", 1'b0, 1'b0, 1'b1);
    chk("ignstart_rx_ready", 32'(bus.rx_ready), 1);
    realign();
    send_byte(8'h00, 1'b1, 1, 1'b0);
    send_byte(8'h00, 1'b1, 2, 1'b0);
    send_byte(8'h00, 1'b1, 3, 1'b0);
    @(negedge clk);
    chk_flags("ignstart_chk", 1'b0, 1'b0, 1'b1);
    realign();
    send_byte(8'h13, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk_flags("ignstart_done", 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
